// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline-stage types: state encoding, occupancy width, per-boundary control bundles
package pipe_pkg;

  localparam int PIPE_OCC_W = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_state_e;

  typedef struct packed {
    logic        pred_taken;
    logic        instr_fault;
    logic [29:0] rsvd;
  } fd_ctrl_t;

  // Sized to 32 bits so the default CTRL_W of pipe_stage matches this bundle.
  typedef struct packed {
    logic [4:0] alu_op;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] br_type;
    logic       mem_rd;
    logic       mem_wr;
    logic [1:0] mem_size;
    logic       mem_unsigned;
    logic [1:0] wb_sel;
    logic       reg_wr;
    logic [4:0] rd;
    logic [2:0] csr_op;
    logic       illegal;
    logic [2:0] rsvd;
  } de_ex_ctrl_t;

  typedef struct packed {
    logic       mem_rd;
    logic       mem_wr;
    logic [1:0] mem_size;
    logic       mem_unsigned;
    logic [1:0] wb_sel;
    logic       reg_wr;
    logic [4:0] rd;
  } ex_mem_ctrl_t;

  typedef struct packed {
    logic [1:0] wb_sel;
    logic       reg_wr;
    logic [4:0] rd;
  } mem_wb_ctrl_t;

  function automatic logic [PIPE_OCC_W-1:0] occ_of_state(input pipe_state_e s);
    case (s)
      FULL:    return 2'd1;
      SKID:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// rtl/pipe_entry_reg.sv - one payload register with load enable and asynchronous active-low clear
module pipe_entry_reg #(
  parameter int W = 128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/pipe_stage.sv
// rtl/pipe_stage.sv - valid/ready pipeline stage register with stall and flush;
// defining PIPE_STAGE_SKID_EN adds a skid entry and a registered in_ready.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int                DATA_W      = 96,
  parameter int                CTRL_W      = $bits(de_ex_ctrl_t),
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [CTRL_W-1:0]     in_ctrl,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [CTRL_W-1:0]     out_ctrl,
  output logic [PIPE_OCC_W-1:0] occupancy
);

  localparam int ENTRY_W = DATA_W + CTRL_W;

  pipe_state_e           state_q, state_d;
  logic [PIPE_OCC_W-1:0] occ_q;
  logic [ENTRY_W-1:0]    main_q, main_d;
  logic                  main_load;
  logic                  accept, out_xfer;

  assign out_valid = (state_q != EMPTY);
  assign out_xfer  = out_valid & out_ready;
  assign accept    = in_valid & in_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic               in_ready_q;
  logic [ENTRY_W-1:0] skid_q;
  logic               skid_load;

  // Flush still gates acceptance so a same-cycle input is never taken.
  assign in_ready = in_ready_q & ~flush;

  always_comb begin
    state_d   = state_q;
    main_load = 1'b0;
    skid_load = 1'b0;
    main_d    = {in_ctrl, in_data};
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d   = FULL;
            main_load = 1'b1;
          end
        end
        FULL: begin
          if (accept && !out_xfer) begin
            state_d   = SKID;
            skid_load = 1'b1;
          end else if (accept) begin
            main_load = 1'b1;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end
        end
        SKID: begin
          if (out_xfer) begin
            state_d   = FULL;
            main_load = 1'b1;
            main_d    = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  pipe_entry_reg #(.W(ENTRY_W)) u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (skid_load),
    .d_i    ({in_ctrl, in_data}),
    .q_o    (skid_q)
  );

  // Stall is seen one cycle late; the skid entry catches the word already in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q <= 1'b1;
    end else begin
      in_ready_q <= ~stall & (state_d != SKID);
    end
  end
`else
  assign in_ready = ~stall & ~flush & (~out_valid | out_ready);
  assign main_d   = {in_ctrl, in_data};

  always_comb begin
    state_d   = state_q;
    main_load = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d   = FULL;
            main_load = 1'b1;
          end
        end
        FULL: begin
          if (accept) begin
            main_load = 1'b1;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end
`endif

  pipe_entry_reg #(.W(ENTRY_W)) u_main (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (main_load),
    .d_i    (main_d),
    .q_o    (main_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      occ_q   <= '0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_of_state(state_d);
    end
  end

  assign occupancy = occ_q;
  assign out_data  = main_q[DATA_W-1:0];
  // Bubble is muxed from the valid bit so a stale control word never leaks downstream.
  assign out_ctrl  = out_valid ? main_q[ENTRY_W-1:DATA_W] : CTRL_BUBBLE;

endmodule

// File: tb/tb_pipe_stage.sv
// tb/tb_pipe_stage.sv - directed self-checking bench for pipe_stage (base or PIPE_STAGE_SKID_EN build)
module tb_pipe_stage;

  localparam int          DATA_W = 96;
  localparam int          CTRL_W = 32;
  localparam logic [31:0] BUB    = 32'h3;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              stall;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occupancy;

  int checks = 0;
  int errors = 0;

  pipe_stage #(
    .DATA_W      (DATA_W),
    .CTRL_W      (CTRL_W),
    .CTRL_BUBBLE (BUB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .stall     (stall),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ctrl_of(input logic [95:0] d);
    return 32'hC0DE_0000 | {16'h0, d[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic [95:0] d);
    in_valid = 1'b1;
    in_data  = d;
    in_ctrl  = ctrl_of(d);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0;
    stall = 1'b0; flush = 1'b0; out_ready = 1'b0;

    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ctrl", out_ctrl, BUB);
    chk("rst_occupancy", occupancy, 0);
    #9 rst_n = 1'b1;
    tick();
    chk("idle_in_ready", in_ready, 1);
    chk("idle_bubble", out_ctrl, BUB);

    // Streaming at full throughput
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      drive(96'(i));
      settle();
      chk("stream_in_ready", in_ready, 1);
      tick();
      chk("stream_out_data", out_data, 128'(i));
      chk("stream_out_ctrl", out_ctrl, ctrl_of(96'(i)));
      chk("stream_occupancy", occupancy, 1);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drained_valid", out_valid, 0);
    chk("stream_drained_ctrl", out_ctrl, BUB);
    chk("stream_drained_occ", occupancy, 0);

    // Backpressure
    out_ready = 1'b0;
    drive(96'hA);
    tick();
    drive(96'hB);
    settle();
`ifdef PIPE_STAGE_SKID_EN
    chk("bp_first_in_ready", in_ready, 1);
`else
    chk("bp_first_in_ready", in_ready, 0);
`endif
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_data", out_data, 96'hA);
      chk("bp_hold_in_ready", in_ready, 0);
`ifdef PIPE_STAGE_SKID_EN
      chk("bp_hold_occ", occupancy, 2);
`else
      chk("bp_hold_occ", occupancy, 1);
`endif
    end
    out_ready = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
    in_valid = 1'b0;
`endif
    settle();
    chk("bp_release_head", out_data, 96'hA);
    chk("bp_release_valid", out_valid, 1);
    tick();
    in_valid = 1'b0;
    chk("bp_second_data", out_data, 96'hB);
    chk("bp_second_valid", out_valid, 1);
    chk("bp_second_occ", occupancy, 1);
    tick();
    chk("bp_empty_valid", out_valid, 0);
    chk("bp_empty_occ", occupancy, 0);

    // Flush with simultaneous input
    out_ready = 1'b0;
    drive(96'h5);
    tick();
    chk("flush_pre_data", out_data, 96'h5);
    flush = 1'b1;
    drive(96'h6);
    settle();
    chk("flush_in_ready", in_ready, 0);
    tick();
    chk("flush_out_valid", out_valid, 0);
    chk("flush_out_ctrl", out_ctrl, BUB);
    chk("flush_occ", occupancy, 0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("flush_no_ghost", out_valid, 0);

    // Stall drain
    out_ready = 1'b0;
    drive(96'h7);
    tick();
    in_valid = 1'b0; stall = 1'b1; out_ready = 1'b1;
    settle();
`ifndef PIPE_STAGE_SKID_EN
    chk("stall_in_ready_now", in_ready, 0);
`endif
    chk("stall_drain_data", out_data, 96'h7);
    chk("stall_drain_valid", out_valid, 1);
    tick();
    chk("stall_empty_valid", out_valid, 0);
    chk("stall_empty_occ", occupancy, 0);
    chk("stall_in_ready", in_ready, 0);
    drive(96'h8);
    settle();
    chk("stall_block_ready", in_ready, 0);
    tick();
    chk("stall_block_valid", out_valid, 0);
    in_valid = 1'b0; stall = 1'b0;
    tick();
    chk("unstall_in_ready", in_ready, 1);

    // Asynchronous reset while holding entries
    out_ready = 1'b0;
    drive(96'h11);
    tick();
    drive(96'h12);
    tick();
    in_valid = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
    chk("arst_pre_occ", occupancy, 2);
`else
    chk("arst_pre_occ", occupancy, 1);
`endif
    chk("arst_pre_data", out_data, 96'h11);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_occ", occupancy, 0);
    chk("arst_out_ctrl", out_ctrl, BUB);
    chk("arst_out_data", out_data, 0);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("arst_after1_valid", out_valid, 0);
    tick();
    chk("arst_after2_valid", out_valid, 0);
    chk("arst_after2_occ", occupancy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
